// File: rtl/riscv_dmem_pkg.sv
// Shared types and constants for the RISC-V data-memory responder.
// The optional DMEM_WAIT_STATE_EN feature lives in riscv_dmem_responder.sv.
package riscv_dmem_pkg;

    localparam int BYTE_LANES = 4;
    localparam int WORD_W     = 32;

    // WAIT is only ever entered when DMEM_WAIT_STATE_EN is defined.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_e;

    // Replace the bytes of old_word selected by be with the matching bytes of new_word.
    function automatic logic [WORD_W-1:0] byte_merge(
        input logic [WORD_W-1:0]     old_word,
        input logic [WORD_W-1:0]     new_word,
        input logic [BYTE_LANES-1:0] be
    );
        logic [WORD_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (be[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end else begin
                merged[i*8 +: 8] = old_word[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/riscv_dmem_bank.sv
// Single-port word storage with byte-lane write enables.
// Writes land on the rising edge; the read port is a plain array lookup so
// the responder can capture the full word on the same edge it accepts a load.
// Contents are deliberately not reset.
module riscv_dmem_bank
    import riscv_dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [WORD_W-1:0]     wdata,
    input  logic [BYTE_LANES-1:0] be,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem_r [DEPTH_WORDS];

    // Byte-enabled write; unselected lanes keep their previous contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= byte_merge(mem_r[addr], wdata, be);
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/riscv_dmem_responder.sv
// Load/store responder for a RISC-V core data port.
// One transaction at a time: IDLE accepts, RESP holds the response until
// the core takes it. Defining DMEM_WAIT_STATE_EN inserts a WAIT state that
// adds WAIT_CYCLES of latency before the response is presented.
module riscv_dmem_responder
    import riscv_dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [WORD_W-1:0]     req_wdata,
    input  logic [BYTE_LANES-1:0] req_be,
    output logic                  rsp_valid,
    output logic [WORD_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    input  logic                  rsp_ready
);

    localparam int                BANK_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH_WORDS);

    dmem_state_e         state_r;
    dmem_state_e         next_state_s;
    logic                accept_s;
    logic                err_s;
    logic                hs_s;
    logic                bank_we_s;
    logic [ADDR_W-3:0]   word_idx_s;
    logic [BANK_AW-1:0]  bank_addr_s;
    logic [WORD_W-1:0]   bank_rdata_s;
    logic                rsp_valid_r;
    logic [WORD_W-1:0]   rsp_rdata_r;
    logic                rsp_err_r;
    logic                unused_addr_lsb_s;

`ifdef DMEM_WAIT_STATE_EN
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] wait_cnt_next_s;
`endif

    // Holding reset_n in the ready term keeps requests out while reset is applied.
    assign req_ready  = (state_r == IDLE) && reset_n;
    assign accept_s   = req_valid && req_ready;
    assign hs_s       = rsp_valid_r && rsp_ready;

    // Word addressing: the two byte-offset bits play no part.
    assign word_idx_s        = req_addr[ADDR_W-1:2];
    assign unused_addr_lsb_s = ^req_addr[1:0];
    assign bank_addr_s       = word_idx_s[BANK_AW-1:0];

    // Out-of-range words and empty byte masks are rejected without touching storage.
    assign err_s     = ({2'b00, word_idx_s} >= DEPTH_L) || (req_be == 4'b0000);
    assign bank_we_s = accept_s && req_we && !err_s;

    riscv_dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (BANK_AW)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we_s),
        .addr  (bank_addr_s),
        .wdata (req_wdata),
        .be    (req_be),
        .rdata (bank_rdata_s)
    );

    // Next-state logic, including the wait-counter schedule when enabled.
    always_comb begin
        next_state_s = state_r;
`ifdef DMEM_WAIT_STATE_EN
        wait_cnt_next_s = wait_cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (accept_s) begin
`ifdef DMEM_WAIT_STATE_EN
                    if (WAIT_CYCLES == 0) begin
                        next_state_s = RESP;
                    end else begin
                        next_state_s    = WAIT;
                        wait_cnt_next_s = CNT_W'(WAIT_CYCLES);
                    end
`else
                    next_state_s = RESP;
`endif
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT: begin
`ifdef DMEM_WAIT_STATE_EN
                // Leave on the last waiting cycle; <= also recovers from a zero count.
                if (wait_cnt_r <= CNT_W'(1)) begin
                    next_state_s    = RESP;
                    wait_cnt_next_s = {CNT_W{1'b0}};
                end else begin
                    next_state_s    = WAIT;
                    wait_cnt_next_s = wait_cnt_r - CNT_W'(1);
                end
`else
                next_state_s = IDLE;
`endif
            end
            RESP: begin
                if (hs_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register; reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

`ifdef DMEM_WAIT_STATE_EN
    // Wait-cycle down-counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else begin
            wait_cnt_r <= wait_cnt_next_s;
        end
    end
`endif

    // Response registers: data/error captured at acceptance, valid follows RESP.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {WORD_W{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            rsp_valid_r <= (next_state_s == RESP);
            if (accept_s) begin
                rsp_err_r <= err_s;
                if (err_s || req_we) begin
                    rsp_rdata_r <= {WORD_W{1'b0}};
                end else begin
                    rsp_rdata_r <= bank_rdata_s;
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed, table-driven bench for riscv_dmem_responder plus hand-written
// sequences for response back-pressure and mid-transaction reset.
module tb_riscv_dmem_responder;

    localparam int ADDR_W      = 32;
    localparam int DEPTH_WORDS = 256;
    localparam int WAIT_CYCLES = 2;
`ifdef DMEM_WAIT_STATE_EN
    localparam int EXP_LAT = WAIT_CYCLES + 1;
`else
    localparam int EXP_LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_be;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              rsp_ready;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[16];

    always #5 clk = ~clk;

    riscv_dmem_responder #(
        .ADDR_W      (ADDR_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One full transaction: issue, measure latency, optionally stall the
    // response for 'hold' cycles, then handshake and check the ready recovery.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err,
                       input int hold, input int idx);
        int guard;
        int lat;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check32($sformatf("v%0d req_ready_idle", idx), {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = 4'h0;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check32($sformatf("v%0d latency", idx), 32'(lat), 32'(EXP_LAT));
        check32($sformatf("v%0d rdata", idx), rsp_rdata, exp_rdata);
        check32($sformatf("v%0d err", idx), {31'b0, rsp_err}, {31'b0, exp_err});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check32($sformatf("v%0d hold%0d valid", idx, i), {31'b0, rsp_valid}, 32'd1);
            check32($sformatf("v%0d hold%0d rdata", idx, i), rsp_rdata, exp_rdata);
            check32($sformatf("v%0d hold%0d req_ready", idx, i), {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check32($sformatf("v%0d ready_after_hs", idx), {31'b0, req_ready}, 32'd1);
        check32($sformatf("v%0d valid_after_hs", idx), {31'b0, rsp_valid}, 32'd0);
    endtask

    initial begin
        // we, addr, wdata, be, expected rdata, expected err
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'hF, 32'h11BB_33DD, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0400, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
        vecs[6]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 4'h0, 32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 4'h1, 32'hDEAD_BEEF, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_03FC, 32'h0102_0304, 4'hF, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_03FC, 32'hA0B0_C0D0, 4'hA, 32'h0000_0000, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_03FC, 32'h0000_0000, 4'hF, 32'hA002_C004, 1'b0};
        vecs[12] = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b0};
        vecs[13] = '{1'b1, 32'h0000_0400, 32'h5555_5555, 4'hF, 32'h0000_0000, 1'b1};
        vecs[14] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 1'b0};
        vecs[15] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = 4'h0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check32("rst req_ready_low", {31'b0, req_ready}, 32'd0);
        check32("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check32("rst rsp_rdata", rsp_rdata, 32'h0000_0000);
        check32("rst rsp_err", {31'b0, rsp_err}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check32("rst req_ready_high", {31'b0, req_ready}, 32'd1);

        // Table-driven transactions
        for (int v = 0; v < 16; v++) begin
            txn(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].be,
                vecs[v].exp_rdata, vecs[v].exp_err, 0, v);
        end

        // Back-pressure: response held five cycles with rsp_ready low
        txn(1'b0, 32'h0000_0020, 32'h0, 4'hF, 32'h11BB_33DD, 1'b0, 5, 100);

        // Reset in the middle of a transaction
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0010;
        req_be    = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check32("mid req_ready_busy", {31'b0, req_ready}, 32'd0);
        reset_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check32("mid rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
            check32("mid rst req_ready", {31'b0, req_ready}, 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check32("mid post req_ready", {31'b0, req_ready}, 32'd1);
        check32("mid post rsp_rdata", rsp_rdata, 32'h0000_0000);
        check32("mid post rsp_err", {31'b0, rsp_err}, 32'd0);

        // Storage survives reset
        txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 0, 200);
        txn(1'b0, 32'h0000_03FC, 32'h0, 4'hF, 32'hA002_C004, 1'b0, 0, 201);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
